board_io_conditioner: RTL and testbench
=======================================

BOARD_IO_CONDITIONER -- requirements
Module: board_io_conditioner

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of button channels, range 1..16.
REQ-002 SHALL have parameter DEBOUNCE_W, default 16: width of the debounce counter and of debounce_limit.
REQ-003 SHALL have parameter POR_CYCLES, default 8: core reset stretch length in clk cycles, range 1..255.
REQ-004 SHALL have parameter ACTIVE_LOW_MASK, default 'b0001, CHANNELS bits: a 1 marks the channel as active-low at the pin.
REQ-005 SHALL have port clk, input, 1: the single clock; all state is in this domain.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port btn_raw, input, CHANNELS: asynchronous button pins.
REQ-008 SHALL have port debounce_limit, input, DEBOUNCE_W: required stable-cycle count L; a value of 0 behaves as 1.
REQ-009 SHALL have port sw_rst, input, 1: synchronous request to restart the core reset stretch.
REQ-010 SHALL have port btn_level, output, CHANNELS: debounced level, normalised so that 1 = pressed.
REQ-011 SHALL have port btn_rise, output, CHANNELS: one-cycle press pulse.
REQ-012 SHALL have port btn_fall, output, CHANNELS: one-cycle release pulse.
REQ-013 SHALL have port core_rst_n, output, 1: stretched active-low reset for the downstream core.

Function
REQ-014 SHALL pass each btn_raw bit through a 2-flop synchroniser; normalised sample n[i] = sync2[i] XOR ACTIVE_LOW_MASK[i].
REQ-015 SHALL keep, per channel, a counter cnt[i] with this update rule:
- n[i] == btn_level[i]: cnt[i] <= 0.
- otherwise: cnt[i] <= cnt[i]+1.
- when cnt[i]+1 reaches L: btn_level[i] <= n[i] and cnt[i] <= 0 in the same edge.
REQ-016 SHALL, for a raw change captured at edge k and held stable, update btn_level at edge k+1+L (L=1 gives k+2).
REQ-017 SHALL discard a glitch shorter than L cycles: btn_level is unchanged and cnt returns to 0.
REQ-018 SHALL take debounce_limit as live; a change applies from the next comparison, and cnt never exceeds L-1 after an update.
REQ-019 SHALL register btn_rise[i]/btn_fall[i] at the same edge btn_level[i] goes 0->1 / 1->0, high for exactly one cycle; never both high at once.
REQ-020 SHALL run channels independently; simultaneous transitions on several channels each produce their own pulses in the same cycle.
REQ-021 SHALL run the POR stretch FSM with states HOLD and RUN:
- HOLD: core_rst_n=0; por_cnt increments each cycle; goes to RUN on the edge where por_cnt reaches POR_CYCLES-1.
- RUN: core_rst_n=1.
REQ-022 SHALL, when sw_rst=1 in any state, load por_cnt to 0 and enter HOLD at that edge, so core_rst_n is 0 from the next cycle; sw_rst in HOLD restarts the full count.
REQ-023 SHALL drive core_rst_n from a register only; it is never combinational from inputs except for the asynchronous rst_n path.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously force:
- sync flops to ACTIVE_LOW_MASK, so that n=0;
- cnt=0, btn_level=0, btn_rise=0, btn_fall=0;
- por_cnt=0, state HOLD, core_rst_n=0.
REQ-025 SHALL, after rst_n rises, hold core_rst_n low for exactly POR_CYCLES clk edges.
REQ-026 SHALL, on rst_n asserted mid-debounce or mid-stretch, abandon all progress with no pulse emitted.
REQ-027 SHALL not emit a press pulse at reset release for an active-low pin idling high.

Configuration
REQ-028 SHALL compile in the edge-pulse logic when macro VSLC_BTN_EDGE_PULSE_EN is defined; btn_rise/btn_fall then behave per REQ-019.
REQ-029 SHALL, when VSLC_BTN_EDGE_PULSE_EN is undefined, tie btn_rise and btn_fall to constant 0 and omit their registers; all other behaviour is unchanged.

Verification
REQ-030 SHALL cover: CHANNELS=4, L=3, btn_raw[1] 0->1 held at edge k -> btn_level[1]=1 and btn_rise[1]=1 at edge k+4, btn_rise low at edge k+5.
REQ-031 SHALL cover: L=4, btn_raw[2] pulse high for 2 cycles -> btn_level[2] stays 0, no pulse, cnt[2] back to 0.
REQ-032 SHALL cover: ACTIVE_LOW_MASK=0001, btn_raw[0]=1 through reset release -> btn_level[0]=0; drive 0 for L cycles -> btn_level[0]=1 and btn_rise[0] pulse.
REQ-033 SHALL cover: POR_CYCLES=8, rst_n released at edge 0 -> core_rst_n low through edge 7, high after edge 8; sw_rst at edge 5 -> high only after edge 13.
REQ-034 SHALL cover: channels 0 and 3 released in the same cycle with L=1 -> btn_fall[0] and btn_fall[3] high in the same single cycle.
REQ-035 SHALL cover: rst_n pulsed low while cnt[1]=2 of L=5 -> all outputs 0 immediately; after release, a fresh L cycles are required.

Source files
------------

// File: rtl/board_io_conditioner.sv
// Button synchronise/debounce/edge conditioning plus a stretched core reset.
// Define VSLC_BTN_EDGE_PULSE_EN to build the btn_rise/btn_fall pulse registers.

module board_io_chan #(
   parameter int   DEBOUNCE_W = 16,
   parameter logic ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  raw,
   input  logic [DEBOUNCE_W-1:0] limit,
   output logic                  level,
   output logic                  rise,
   output logic                  fall
);
   logic [1:0]            sync;
   logic                  n;
   logic                  settle;
   logic [DEBOUNCE_W-1:0] cnt;
   logic [DEBOUNCE_W:0]   cnt_inc;

   // Sync flops reset to the idle pin level so a held active-low pin reads released.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync <= {2{ACTIVE_LOW}};
      else        sync <= {sync[0], raw};

   assign n       = sync[1] ^ ACTIVE_LOW;
   assign cnt_inc = {1'b0, cnt} + {{DEBOUNCE_W{1'b0}}, 1'b1};
   // >= keeps cnt below L even when the limit is lowered mid-count.
   assign settle  = (n != level) && (cnt_inc >= {1'b0, limit});

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (n == level) begin
         cnt   <= '0;
      end else if (settle) begin
         cnt   <= '0;
         level <= n;
      end else begin
         cnt   <= cnt_inc[DEBOUNCE_W-1:0];
      end

`ifdef VSLC_BTN_EDGE_PULSE_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= settle & n;
         fall <= settle & ~n;
      end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif
endmodule

module board_io_conditioner #(
   parameter int                  CHANNELS        = 4,
   parameter int                  DEBOUNCE_W      = 16,
   parameter int                  POR_CYCLES      = 8,
   parameter logic [CHANNELS-1:0] ACTIVE_LOW_MASK = CHANNELS'(1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [CHANNELS-1:0]   btn_raw,
   input  logic [DEBOUNCE_W-1:0] debounce_limit,
   input  logic                  sw_rst,
   output logic [CHANNELS-1:0]   btn_level,
   output logic [CHANNELS-1:0]   btn_rise,
   output logic [CHANNELS-1:0]   btn_fall,
   output logic                  core_rst_n
);
   localparam logic [7:0] POR_LAST = 8'(POR_CYCLES - 1);

   typedef enum logic {HOLD, RUN} state_t;

   logic [DEBOUNCE_W-1:0] limit_eff;
   state_t                state, state_nx;
   logic [7:0]            por_cnt, por_nx;

   // A zero limit settles after one cycle, same as a limit of one.
   assign limit_eff = (debounce_limit == '0) ? {{(DEBOUNCE_W-1){1'b0}}, 1'b1} : debounce_limit;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      board_io_chan #(
         .DEBOUNCE_W (DEBOUNCE_W),
         .ACTIVE_LOW (ACTIVE_LOW_MASK[i])
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (btn_raw[i]),
         .limit (limit_eff),
         .level (btn_level[i]),
         .rise  (btn_rise[i]),
         .fall  (btn_fall[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= HOLD;
         por_cnt    <= '0;
         core_rst_n <= 1'b0;
      end else begin
         state      <= state_nx;
         por_cnt    <= por_nx;
         core_rst_n <= (state_nx == RUN);
      end

   always_comb begin
      state_nx = state;
      por_nx   = por_cnt;
      if (sw_rst) begin
         state_nx = HOLD;
         por_nx   = '0;
      end else begin
         case (state)
            HOLD:    if (por_cnt == POR_LAST) state_nx = RUN;
                     else                     por_nx   = por_cnt + 8'd1;
            default: state_nx = RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_board_io_conditioner.sv
// Randomised scoreboard bench for board_io_conditioner against a run-length/countdown model.
// Honours VSLC_BTN_EDGE_PULSE_EN so pulse expectations track the build.

module tb_board_io_conditioner;
   localparam int             CH   = 4;
   localparam int             DW   = 8;
   localparam int             POR  = 8;
   localparam logic [CH-1:0]  MASK = 4'b0001;
`ifdef VSLC_BTN_EDGE_PULSE_EN
   localparam bit PULSE_EN = 1'b1;
`else
   localparam bit PULSE_EN = 1'b0;
`endif

   typedef struct packed {
      logic [CH-1:0] lvl;
      logic [CH-1:0] rise;
      logic [CH-1:0] fall;
      logic          core;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] btn_raw;
   logic [DW-1:0] debounce_limit;
   logic          sw_rst;
   logic [CH-1:0] btn_level, btn_rise, btn_fall;
   logic          core_rst_n;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors = 0;
   int   errs    = 0;

   // model state: pin pipeline, believed level, run of disagreeing samples, reset countdown
   logic [CH-1:0] m_s1, m_s2, m_lvl;
   int            m_run[CH];
   int            m_rem;
   logic          m_core;

   board_io_conditioner #(
      .CHANNELS(CH), .DEBOUNCE_W(DW), .POR_CYCLES(POR), .ACTIVE_LOW_MASK(MASK)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .debounce_limit(debounce_limit),
      .sw_rst(sw_rst), .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
      .core_rst_n(core_rst_n)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_s1   = MASK;
      m_s2   = MASK;
      m_lvl  = '0;
      foreach (m_run[i]) m_run[i] = 0;
      m_rem  = POR;
      m_core = 1'b0;
   endfunction

   // Predict the outputs after the coming posedge from the inputs now driven, then wait it out.
   task automatic tick();
      exp_t          e;
      logic [CH-1:0] n;
      int            lim;
      e = '0;
      if (!rst_n) begin
         model_reset();
      end else begin
         n    = m_s2 ^ MASK;
         m_s2 = m_s1;
         m_s1 = btn_raw;
         lim  = (debounce_limit == 0) ? 1 : int'(debounce_limit);
         for (int i = 0; i < CH; i++) begin
            if (n[i] == m_lvl[i]) m_run[i] = 0;
            else begin
               m_run[i]++;
               if (m_run[i] >= lim) begin
                  m_lvl[i] = n[i];
                  m_run[i] = 0;
                  if (PULSE_EN) begin
                     if (n[i]) e.rise[i] = 1'b1;
                     else      e.fall[i] = 1'b1;
                  end
               end
            end
         end
         if (sw_rst) begin
            m_rem  = POR;
            m_core = 1'b0;
         end else if (m_rem > 0) begin
            m_rem--;
            m_core = (m_rem == 0);
         end
         e.lvl  = m_lvl;
         e.core = m_core;
      end
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   // Asynchronous reset between edges; outputs must clear at once.
   task automatic pulse_reset(input int hold);
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({btn_level, btn_rise, btn_fall, core_rst_n} !== '0) begin
         errs++;
         $display("FAIL async_reset_clear got lvl=%b rise=%b fall=%b core=%b want all 0",
                  btn_level, btn_rise, btn_fall, core_rst_n);
      end
      model_reset();
      repeat (hold) tick();
      rst_n = 1'b1;
   endtask

   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         vectors++;
         if (btn_level !== mon_e.lvl || btn_rise !== mon_e.rise ||
             btn_fall !== mon_e.fall || core_rst_n !== mon_e.core) begin
            errs++;
            $display("FAIL outputs t=%0t got lvl=%b rise=%b fall=%b core=%b want lvl=%b rise=%b fall=%b core=%b",
                     $time, btn_level, btn_rise, btn_fall, core_rst_n,
                     mon_e.lvl, mon_e.rise, mon_e.fall, mon_e.core);
         end
      end
   end

   initial begin
      int idx;
      rst_n          = 1'b0;
      btn_raw        = MASK;        // active-low channel 0 idles high through reset
      debounce_limit = DW'(3);
      sw_rst         = 1'b0;
      model_reset();
      @(negedge clk);
      repeat (2) tick();
      rst_n = 1'b1;
      run(12);                      // reset stretch; no press pulse on channel 0

      // single press on channel 1, L=3
      btn_raw[1] = 1'b1;
      run(8);

      // 2-cycle glitch on channel 2 with L=4 is discarded
      debounce_limit = DW'(4);
      btn_raw[2] = 1'b1;
      run(2);
      btn_raw[2] = 1'b0;
      run(8);

      // active-low press on channel 0
      debounce_limit = DW'(3);
      btn_raw[0] = 1'b0;
      run(6);

      // software reset restart of the stretch, including mid-stretch restart
      sw_rst = 1'b1; tick(); sw_rst = 1'b0;
      run(4);
      sw_rst = 1'b1; tick(); sw_rst = 1'b0;
      run(12);

      // simultaneous releases on channels 0 and 3 with L=1 (and L=0 acting as 1)
      debounce_limit = DW'(1);
      btn_raw[3] = 1'b1;
      run(5);
      debounce_limit = DW'(0);
      btn_raw[0] = 1'b1;
      btn_raw[3] = 1'b0;
      run(5);

      // reset mid-debounce on channel 1 (L=5): progress abandoned, fresh count after release
      debounce_limit = DW'(5);
      btn_raw[1] = 1'b0;
      run(10);
      btn_raw[1] = 1'b1;
      run(4);
      pulse_reset(2);
      run(14);

      // randomised traffic
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) begin
            idx = $urandom_range(0, CH-1);
            btn_raw[idx] = ~btn_raw[idx];
         end
         if ($urandom_range(0, 99) == 0) debounce_limit = DW'($urandom_range(0, 6));
         sw_rst = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 699) == 0) begin
            sw_rst = 1'b0;
            pulse_reset($urandom_range(1, 3));
         end else begin
            tick();
         end
      end
      sw_rst = 1'b0;
      run(3);
      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
